// File: rtl/truth_table_sweeper_pkg.sv
// tt_pkg: shared FSM state type, vector count and vector-to-table-bit mapping
package tt_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam int NUM_VECTORS = 8;
  localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);
  function automatic logic [2:0] bit_idx(input logic [2:0] idx);
    return LAST_IDX - idx;
  endfunction
endpackage

// File: rtl/truth_table_sweeper_sync2.sv
// tt_sync2: two-flop synchronizer, resets to 0
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 3-input vectors, waits settle_q+1 cycles each, captures the gate's truth table.
// Define TT_SYNC_EN to pass dut_out through a two-flop synchronizer before sampling.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [7:0]          expected,
  output logic [2:0]          drv,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic [7:0]          table_out,
  output logic [7:0]          mismatch,
  output logic                match
);
  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d, drv_q, drv_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d, settle_q, settle_d;
  logic [7:0]          expected_q, expected_d, table_q, table_d;
  logic                done_q, done_d, busy_q, busy_d, samp;

`ifdef TT_SYNC_EN
  tt_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(dut_out), .q(samp));
`else
  assign samp = dut_out;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    expected_d = expected_q;
    table_d    = table_q;
    if (abort) state_d = IDLE;
    else
      unique case (state_q)
        IDLE:
          if (start) begin
            settle_d   = settle_cycles;
            expected_d = expected;
            table_d    = 8'h00;
            idx_d      = 3'd0;
            cnt_d      = settle_cycles;
            state_d    = SETTLE;
          end
        SETTLE:
          if (cnt_q == '0) state_d = SAMPLE;
          else cnt_d = cnt_q - SETTLE_W'(1);
        SAMPLE: begin
          table_d[bit_idx(idx_q)] = samp;
          if (idx_q == LAST_IDX) state_d = DONE;
          else begin
            idx_d   = idx_q + 3'd1;
            cnt_d   = settle_q;
            state_d = SETTLE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    // outputs are registered from the next state so they line up with it
    drv_d  = (state_d == SETTLE || state_d == SAMPLE) ? idx_d : 3'd0;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      settle_q   <= '0;
      expected_q <= 8'h00;
      table_q    <= 8'h00;
      drv_q      <= 3'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      expected_q <= expected_d;
      table_q    <= table_d;
      drv_q      <= drv_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end

  assign drv       = drv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign mismatch  = table_q ^ expected_q;
  assign match     = mismatch == 8'h00;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized self-checking bench with a cycle-count reference model of the sweep
module tb_truth_table_sweeper;
`ifdef TT_SYNC_EN
  localparam int MIN_S = 2;
`else
  localparam int MIN_S = 0;
`endif
  localparam logic [7:0] REF_GATE = 8'hC1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] settle_cycles = 8'd0;
  logic [7:0] expected = 8'd0;
  logic [2:0] drv;
  logic       dut_out;
  logic       busy, done, match;
  logic [7:0] table_out, mismatch;
  logic [7:0] gmap = REF_GATE;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;
  assign dut_out = gmap[drv];

  truth_table_sweeper #(.SETTLE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .settle_cycles(settle_cycles), .expected(expected), .drv(drv),
    .dut_out(dut_out), .busy(busy), .done(done),
    .table_out(table_out), .mismatch(mismatch), .match(match)
  );

  function automatic logic [7:0] model_tbl(input logic [7:0] g, input int nvec);
    logic [7:0] t = 8'h00;
    for (int v = 0; v < nvec; v++) t[7-v] = g[v];
    return t;
  endfunction

  // Runs one sweep; called at #1 after an edge. Checks drv/busy/done every cycle against
  // the timeline: vector v occupies s+2 cycles, then one done cycle, then idle.
  task automatic run_sweep(input int s, input logic [7:0] e, input int restart_at,
                           input int abort_at, output int done_cyc, output int ndone);
    int per = s + 2;
    int k;
    logic eb, ed;
    logic [2:0] ev;
    done_cyc = -1;
    ndone = 0;
    start = 1'b1;
    settle_cycles = 8'(s);
    expected = e;
    @(posedge clk); #1;
    start = 1'b0;
    settle_cycles = 8'($urandom_range(0, 255));
    expected = ~e;
    for (int c = 1; c <= 8 * per + 3; c++) begin
      k = c - 1;
      if ((abort_at > 0 && c > abort_at) || k > 8 * per) begin
        eb = 1'b0; ed = 1'b0; ev = 3'd0;
      end else if (k == 8 * per) begin
        eb = 1'b1; ed = 1'b1; ev = 3'd0;
      end else begin
        eb = 1'b1; ed = 1'b0; ev = 3'(k / per);
      end
      total++;
      if (drv !== ev || busy !== eb || done !== ed) begin
        bad++;
        $display("FAIL timeline c=%0d s=%0d: drv=%0d busy=%b done=%b, required drv=%0d busy=%b done=%b",
                 c, s, drv, busy, done, ev, eb, ed);
      end
      if (done === 1'b1) begin
        ndone++;
        done_cyc = c;
      end
      start = (c == restart_at);
      abort = (c == abort_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (drv !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || table_out !== 8'h00 ||
        mismatch !== 8'h00 || match !== 1'b1) begin
      bad++;
      $display("FAIL reset: drv=%0d busy=%b done=%b tbl=%h mm=%h match=%b, required 0 0 0 00 00 1",
               drv, busy, done, table_out, mismatch, match);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ref_match;
    int dc, nd;
    gmap = REF_GATE;
    run_sweep(3, 8'h83, 0, 0, dc, nd);
    total++;
    if (dc !== 41 || nd !== 1) begin
      bad++;
      $display("FAIL ref_done: cycle=%0d count=%0d, required cycle=41 count=1", dc, nd);
    end
    total++;
    if (table_out !== 8'h83 || mismatch !== 8'h00 || match !== 1'b1) begin
      bad++;
      $display("FAIL ref_match: tbl=%h mm=%h match=%b, required 83 00 1", table_out, mismatch, match);
    end
  endtask

  task automatic test_ref_mismatch;
    int dc, nd;
    gmap = REF_GATE;
    run_sweep(3, 8'h80, 0, 0, dc, nd);
    total++;
    if (table_out !== 8'h83 || mismatch !== 8'h03 || match !== 1'b0) begin
      bad++;
      $display("FAIL ref_mismatch: tbl=%h mm=%h match=%b, required 83 03 0", table_out, mismatch, match);
    end
  endtask

  task automatic test_settle0;
    int dc, nd;
    gmap = 8'($urandom);
    run_sweep(0, 8'h00, 0, 0, dc, nd);
    total++;
    if (dc !== 17 || nd !== 1) begin
      bad++;
      $display("FAIL settle0_done: cycle=%0d count=%0d, required cycle=17 count=1", dc, nd);
    end
`ifndef TT_SYNC_EN
    total++;
    if (table_out !== model_tbl(gmap, 8)) begin
      bad++;
      $display("FAIL settle0_table: tbl=%h, required %h", table_out, model_tbl(gmap, 8));
    end
`endif
  endtask

  task automatic test_restart_ignored;
    int dc, nd;
    gmap = REF_GATE;
    run_sweep(2, 8'h83, 10, 0, dc, nd);
    total++;
    if (dc !== 33 || nd !== 1) begin
      bad++;
      $display("FAIL restart_ignored: cycle=%0d count=%0d, required cycle=33 count=1", dc, nd);
    end
    total++;
    if (table_out !== 8'h83 || match !== 1'b1) begin
      bad++;
      $display("FAIL restart_table: tbl=%h match=%b, required 83 1", table_out, match);
    end
  endtask

  task automatic test_abort;
    int dc, nd;
    logic [7:0] want;
    gmap = 8'($urandom) | 8'h0F;
    want = model_tbl(gmap, 4);
    run_sweep(3, 8'hFF, 4 * 5 + 1, 4 * 5 + 1, dc, nd);
    total++;
    if (nd !== 0) begin
      bad++;
      $display("FAIL abort_nodone: count=%0d, required 0", nd);
    end
    total++;
    if (table_out !== want) begin
      bad++;
      $display("FAIL abort_table: tbl=%h, required %h", table_out, want);
    end
  endtask

  task automatic test_midsweep_reset;
    int dc, nd;
    int seen = 0;
    gmap = REF_GATE;
    start = 1'b1;
    settle_cycles = 8'd3;
    expected = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (drv !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || table_out !== 8'h00 ||
        mismatch !== 8'h00 || match !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: drv=%0d busy=%b done=%b tbl=%h mm=%h match=%b, required 0 0 0 00 00 1",
               drv, busy, done, table_out, mismatch, match);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_abandon: active cycles=%0d, required 0", seen);
    end
    run_sweep(MIN_S, 8'h83, 0, 0, dc, nd);
    total++;
    if (table_out !== 8'h83 || nd !== 1 || dc !== 8 * (MIN_S + 2) + 1) begin
      bad++;
      $display("FAIL post_reset: tbl=%h count=%0d cycle=%0d, required 83 1 %0d",
               table_out, nd, dc, 8 * (MIN_S + 2) + 1);
    end
  endtask

  task automatic test_settle2;
    int dc, nd;
    gmap = REF_GATE;
    run_sweep(2, 8'h83, 0, 0, dc, nd);
    total++;
    if (table_out !== 8'h83 || match !== 1'b1 || dc !== 33) begin
      bad++;
      $display("FAIL settle2: tbl=%h match=%b cycle=%0d, required 83 1 33", table_out, match, dc);
    end
  endtask

  task automatic test_random;
    int dc, nd, s;
    logic [7:0] e, want;
    for (int it = 0; it < 8; it++) begin
      gmap = 8'($urandom);
      s = $urandom_range(MIN_S, 5);
      want = model_tbl(gmap, 8);
      e = it[0] ? want : 8'($urandom);
      run_sweep(s, e, 0, 0, dc, nd);
      total++;
      if (table_out !== want || mismatch !== (want ^ e) || match !== (want == e) ||
          nd !== 1 || dc !== 8 * (s + 2) + 1) begin
        bad++;
        $display("FAIL random it=%0d s=%0d: tbl=%h mm=%h match=%b cycle=%0d, required %h %h %b %0d",
                 it, s, table_out, mismatch, match, dc, want, want ^ e, want == e, 8 * (s + 2) + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ref_match;
    test_ref_mismatch;
    test_settle0;
    test_restart_ignored;
    test_abort;
    test_midsweep_reset;
    test_settle2;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_W, default 8, which is the width of the settle-count input.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port abort  input  1  cancels a sweep in progress.
REQ-006 SHALL have port settle_cycles  input  SETTLE_W  gate propagation wait per vector.
REQ-007 SHALL have port expected  input  8  expected truth-table byte (e.g. 8'h83).
REQ-008 SHALL have port drv  output  3  stimulus to the gate under test, mapped as {in1,in2,in3}.
REQ-009 SHALL have port dut_out  input  1  output of the gate under test.
REQ-010 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-012 SHALL have ports table_out (output, 8) holding the captured truth table, mismatch (output, 8) equal to table_out ^ expected_q, and match (output, 1) equal to (mismatch == 0).

Function
REQ-013 SHALL implement the FSM IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
REQ-014 SHALL act on start only in IDLE: it captures settle_cycles and expected into settle_q and expected_q, clears table_out, sets idx=0 and cnt=settle_q, and goes to SETTLE; start in any other state is ignored.
REQ-015 SHALL drive drv=idx in SETTLE and SAMPLE, and drv=3'b000 in IDLE and DONE.
REQ-016 SHALL, in SETTLE, go to SAMPLE when cnt==0 and otherwise decrement cnt, so SETTLE lasts settle_q+1 cycles; settle_cycles=0 gives exactly one SETTLE cycle.
REQ-017 SHALL, in SAMPLE, write the sampled dut_out into table_out[7-idx] (vector 000 -> bit 7, vector 111 -> bit 0); then, if idx==7, go to DONE, else increment idx, reload cnt=settle_q and go to SETTLE.
REQ-018 SHALL assert done for exactly the DONE cycle and return to IDLE on the following cycle.
REQ-019 SHALL raise done 8*(settle_q+2)+1 cycles after the start edge.
REQ-020 SHALL assert busy in SETTLE, SAMPLE and DONE, and deassert it in IDLE.
REQ-021 SHALL hold table_out, mismatch and match stable from DONE until the next accepted start.
REQ-022 SHALL treat match and mismatch as meaningful only after a done pulse; before the first sweep they show reset values.
REQ-023 SHALL, on abort in any non-IDLE state, go to IDLE the next cycle with drv=000, no done pulse, and table_out keeping its partial contents; abort has priority over start and over every FSM transition.
REQ-024 SHALL let idx wrap only through the restart in REQ-014, never by incrementing past 7.

Reset
REQ-025 SHALL, while rst_n=0, force the state to IDLE, drv=000, idx=0, cnt=0, settle_q=0, expected_q=0, table_out=0, done=0 and busy=0; mismatch=0 and match=1 follow from these.
REQ-026 SHALL abandon any sweep immediately on a mid-sweep reset and produce no done pulse.

Configuration
REQ-027 SHALL, with macro TT_SYNC_EN defined, pass dut_out through a two-flop synchronizer whose output is the sampled value, adding 2 cycles of effective gate latency; the bench then uses settle_cycles >= 2.
REQ-028 SHALL, without TT_SYNC_EN, sample dut_out directly in SAMPLE; the done timing in REQ-019 is identical in both builds.

Structure
REQ-029 SHALL place the FSM state enum, the constant NUM_VECTORS=8 and the bit-index mapping function (7-idx) in the shared package tt_pkg.
REQ-030 SHALL implement the synchronizer as the sub-module tt_sync2 (clk, rst_n, d, q; resets to 0).

Verification
REQ-031 SHALL cover: reference-gate model (out=1 for 000, 110, 111), settle=3, expected=8'h83 -> done at cycle 41, table_out=8'h83, match=1.
REQ-032 SHALL cover: same gate model, expected=8'h80 -> table_out=8'h83, mismatch=8'h03, match=0.
REQ-033 SHALL cover: settle=0 with a combinational model -> done at cycle 17, each vector driven for exactly 2 cycles.
REQ-034 SHALL cover: start pulsed again while busy -> ignored; one done only, at the REQ-019 cycle.
REQ-035 SHALL cover: abort during vector 4 -> IDLE next cycle, drv=000, no done, table_out bits 7..4 kept and bits 3..0 zero.
REQ-036 SHALL cover: rst_n low mid-sweep -> all outputs at REQ-025 values asynchronously; a later start sweeps normally; TT_SYNC_EN build with settle=2 -> table_out=8'h83.
